// File: rtl/core_matrix_seq_if.sv
// ============================================================================
//  Module      : core_matrix_seq_if
//  Description : AXI-lite style access bus between the register slave and
//                core_matrix_seq. The master drives write/read requests.
//                The slave returns registered read data.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface core_matrix_seq_if;
  logic        wready;
  logic [31:0] wr_addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output wready, wr_addr, wdata, rd_en, rd_addr,
    input  rdata, rvalid
  );

  modport slave (
    input  wready, wr_addr, wdata, rd_en, rd_addr,
    output rdata, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/core_matrix_seq.sv
// ============================================================================
//  Module      : core_matrix_seq
//  Description : Clocked control front-end for the NxN coupled-oscillator core.
//                It decodes weight and control accesses into registered
//                one-hot column/shorted-cell write strobes. It also runs the
//                solve sequence: hold the Ising reset, anneal, settle, and
//                then capture the synchronised spins.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module core_matrix_seq #(
  parameter int         N           = 8,
  parameter int         NUM_WEIGHTS = 5,
  parameter logic [7:0] CTRL_MASK   = 8'hC0,
  parameter logic [7:0] WEIGHT_MASK = 8'h00,
  parameter int         RST_CYCLES  = 16,
  parameter int         CNT_W       = 32
) (
  input  wire logic                   clk,
  input  wire logic                   axi_rstn,
  core_matrix_seq_if.slave            bus,
  output logic [N-1:0]                w_col_we,
  output logic [N-1:0]                w_sh_we,
  output logic [10:0]                 w_s_addr,
  output logic [10:0]                 w_d_addr,
  output logic [NUM_WEIGHTS-1:0]      w_data,
  input  wire logic [31:0]            w_rdata_in,
  input  wire logic [N-1:0]           spins_in,
  output logic                        ising_rstn,
  output logic                        busy,
  output logic                        done
);

  localparam int          c_nspw     = (N + 31) / 32;
  localparam logic [N-1:0] c_one     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [31:0] c_bad_addr = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_ANNEAL = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_busy, r_done, r_ising;
  logic [CNT_W-1:0]       r_anneal;
  logic [CNT_W-1:0]       w_anneal_eff;
  logic                   r_wr_err;
  logic [N-1:0]           r_sync1, r_sync2, r_spins;
  logic [N-1:0]           r_col_we, r_sh_we;
  logic [10:0]            r_s_addr, r_d_addr;
  logic [NUM_WEIGHTS-1:0] r_data;
  logic                   r_rvalid, r_rd_wt;
  logic [31:0]            r_rdata;

  logic [31:0]            w_addr;
  logic [10:0]            w_s, w_d, w_k;
  logic [7:0]             w_off;
  logic                   w_is_wt, w_is_ctrl, w_in_range;
  logic                   w_start, w_abort;
  logic [5:0]             w_m;
  logic [c_nspw*32-1:0]   w_spins_pad;
  logic [31:0]            w_ctrl_rdata;

  // Address decode shared by writes and reads; a write owns the decoder when both are present.
  always_comb begin
    w_addr     = bus.wready ? bus.wr_addr : bus.rd_addr;
    w_s        = w_addr[12:2];
    w_d        = w_addr[23:13];
    w_off      = w_addr[7:0];
    w_is_wt    = (w_addr[31:24] == WEIGHT_MASK);
    w_is_ctrl  = !w_is_wt && (w_addr[31:24] == CTRL_MASK);
    w_in_range = ({1'b0, w_s} < 12'(N)) && ({1'b0, w_d} < 12'(N));
    if (w_s >= w_d) begin
      w_k = w_s - w_d;
    end else begin
      w_k = 11'(12'(w_s) + 12'(N) - 12'(w_d));
    end
    w_abort      = bus.wready && w_is_ctrl && (w_off == 8'h00) && bus.wdata[1];
    w_start      = bus.wready && w_is_ctrl && (w_off == 8'h00) && bus.wdata[0] && !bus.wdata[1];
    w_anneal_eff = (r_anneal == '0) ? CNT_W'(1) : r_anneal;
  end

  // Control register read mux, including the zero-padded captured spin words.
  always_comb begin
    w_spins_pad        = '0;
    w_spins_pad[N-1:0] = r_spins;
    w_m                = w_off[7:2] - 6'd4;
    w_ctrl_rdata       = c_bad_addr;
    case (w_off)
      8'h00:   w_ctrl_rdata = 32'h0;
      8'h04:   w_ctrl_rdata = 32'(r_anneal);
      8'h08:   w_ctrl_rdata = {29'b0, r_wr_err, r_done, r_busy};
      default: begin
        if ((w_off >= 8'h10) && (w_off[1:0] == 2'b00) && (int'(w_m) < c_nspw)) begin
          w_ctrl_rdata = w_spins_pad[int'(w_m)*32 +: 32];
        end
      end
    endcase
  end

  // Run sequence next state; abort overrides everything, start only acts from IDLE or DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_state_nxt = S_RESET;
          w_cnt_nxt   = CNT_W'(RST_CYCLES);
        end
      end
      S_RESET: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_ANNEAL;
          w_cnt_nxt   = w_anneal_eff;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ANNEAL: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = CNT_W'(2);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // State register; status outputs are registered so the array reset is glitch-free.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ising <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_RESET) || (w_state_nxt == S_ANNEAL) || (w_state_nxt == S_SETTLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_ising <= (w_state_nxt == S_ANNEAL) || (w_state_nxt == S_SETTLE) || (w_state_nxt == S_DONE);
    end
  end

  // Two-flop spin synchroniser and capture on the SETTLE to DONE transition.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_spins <= '0;
    end else begin
      r_sync1 <= spins_in;
      r_sync2 <= r_sync1;
      if ((r_state == S_SETTLE) && (w_state_nxt == S_DONE)) begin
        r_spins <= r_sync2;
      end
    end
  end

  // Weight/control write path and registered read response.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_col_we <= '0;
      r_sh_we  <= '0;
      r_s_addr <= '0;
      r_d_addr <= '0;
      r_data   <= '0;
      r_anneal <= '0;
      r_wr_err <= 1'b0;
      r_rvalid <= 1'b0;
      r_rd_wt  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_col_we <= '0;
      r_sh_we  <= '0;
      r_rvalid <= bus.rd_en;
      r_rd_wt  <= 1'b0;
      if (bus.wready) begin
        if (w_is_wt) begin
          if (w_in_range) begin
            if (r_busy) begin
              r_wr_err <= 1'b1;
            end else begin
              r_s_addr <= w_s;
              r_d_addr <= w_d;
              r_data   <= bus.wdata[NUM_WEIGHTS-1:0];
              if (w_k == 11'd0) begin
                r_sh_we <= c_one << w_s;
              end else begin
                r_col_we <= c_one << w_k;
              end
            end
          end
        end else if (w_is_ctrl) begin
          case (w_off)
            8'h04:   r_anneal <= bus.wdata[CNT_W-1:0];
            8'h08:   r_wr_err <= 1'b0;
            default: ;
          endcase
        end
      end
      if (bus.rd_en) begin
        if (bus.wready) begin
          r_rdata <= 32'h0;
        end else if (w_is_wt) begin
          if (w_in_range) begin
            // Array readback is combinational on the new index, so it is forwarded in the rvalid cycle.
            r_s_addr <= w_s;
            r_d_addr <= w_d;
            r_rd_wt  <= 1'b1;
            r_rdata  <= 32'h0;
          end else begin
            r_rdata <= c_bad_addr;
          end
        end else if (w_is_ctrl) begin
          r_rdata <= w_ctrl_rdata;
        end else begin
          r_rdata <= c_bad_addr;
        end
      end
    end
  end

  assign bus.rdata  = r_rd_wt ? w_rdata_in : r_rdata;
  assign bus.rvalid = r_rvalid;
  assign w_col_we   = r_col_we;
  assign w_sh_we    = r_sh_we;
  assign w_s_addr   = r_s_addr;
  assign w_d_addr   = r_d_addr;
  assign w_data     = r_data;
  assign ising_rstn = r_ising;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire
